// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame sequencer (start, data LSB first, optional parity, stop)
//
// Purpose:
//   Accepts one parallel word per frame and serializes it onto the TX line.
//   The data word, parity enable and parity type are captured at acceptance,
//   so input changes after that point do not disturb the frame in flight.
//   Outputs are registered and reflect the state being entered on each edge,
//   so TX_OUT and Busy change on the acceptance edge itself.
//
// Configuration:
//   UART_TX_TWO_STOP_EN - when defined, the stop bit lasts two bit periods.
//
// Ports:
//   CLK        in   baud-rate clock, one bit period per cycle
//   RST        in   asynchronous reset, active-high
//   P_DATA     in   word to transmit (DATA_WIDTH bits)
//   Data_Valid in   P_DATA valid strobe, sampled only while idle
//   PAR_EN     in   1 = append parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   TX_OUT     out  serial line, idle-high, registered
//   Busy       out  frame in progress, registered

module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop_cnt_q, stop_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          // Final parity bit is resolved now; odd parity is the even XOR inverted.
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          cnt_d     = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      S_START: begin
        // Shift register always presents the next bit to send at bit 0.
        state_d = S_DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        busy_d  = 1'b1;
      end

      S_DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      S_PARITY: begin
        state_d = S_STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end

      S_STOP: begin
        tx_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        if (!stop_cnt_q) begin
          stop_cnt_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          stop_cnt_d = 1'b0;
          state_d    = S_IDLE;
          busy_d     = 1'b0;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - self-checking bench for uart_tx_frame_ctrl

module tb_uart_tx_frame_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  typedef bit bitq_t[$];

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [9:0] body;   // start + data + parity, bit i = i-th bit on the line
    int         blen;
  } vec_t;

  vec_t vecs[7];

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Reference frame built directly from the framing rules.
  function automatic bitq_t ref_frame(input logic [7:0] d, input logic pe, input logic pt);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back((^d) ^ pt);
    for (int i = 0; i < NSTOP; i++) q.push_back(1'b1);
    return q;
  endfunction

  function automatic bitq_t table_frame(input logic [9:0] body, input int blen);
    bitq_t q;
    for (int i = 0; i < blen; i++) q.push_back(body[i]);
    for (int i = 0; i < NSTOP; i++) q.push_back(1'b1);
    return q;
  endfunction

  // Called just after a negedge. Offers a word, then checks every bit period
  // of the frame plus the idle cycle that follows. hold keeps Data_Valid high
  // after acceptance (next word/config driven instead); inject >= 0 pulses a
  // competing Data_Valid with 0x55 at that bit index.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input bitq_t exp, input bit hold,
                            input logic [7:0] nd, input logic npe, input logic npt,
                            input int inject);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) Data_Valid = 1'b0;
    P_DATA  = nd;
    PAR_EN  = npe;
    PAR_TYP = npt;
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge CLK);
      chk("tx_bit", i, TX_OUT, exp[i]);
      chk("busy", i, Busy, 1'b1);
      if (i == inject) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h55;
      end
      if (inject >= 0 && i == inject + 1) Data_Valid = 1'b0;
    end
    @(negedge CLK);
    chk("idle_tx", exp.size(), TX_OUT, 1'b1);
    chk("idle_busy", exp.size(), Busy, 1'b0);
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("stay_idle_tx", i, TX_OUT, 1'b1);
      chk("stay_idle_busy", i, Busy, 1'b0);
    end
  endtask

  initial begin
    bitq_t q;
    logic [7:0] rd;
    logic rpe, rpt;

    vecs[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, body: 10'h14A, blen: 9};
    vecs[1] = '{d: 8'h07, pe: 1'b1, pt: 1'b0, body: 10'h20E, blen: 10};
    vecs[2] = '{d: 8'h03, pe: 1'b1, pt: 1'b1, body: 10'h206, blen: 10};
    vecs[3] = '{d: 8'h03, pe: 1'b1, pt: 1'b0, body: 10'h006, blen: 10};
    vecs[4] = '{d: 8'hFF, pe: 1'b1, pt: 1'b0, body: 10'h1FE, blen: 10};
    vecs[5] = '{d: 8'hFF, pe: 1'b1, pt: 1'b1, body: 10'h3FE, blen: 10};
    vecs[6] = '{d: 8'h00, pe: 1'b0, pt: 1'b1, body: 10'h000, blen: 9};

    RST = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    @(negedge CLK);
    chk("reset_tx", 0, TX_OUT, 1'b1);
    chk("reset_busy", 0, Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    check_idle(3);

    // Table vectors; inputs are scrambled after acceptance.
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].d, vecs[v].pe, vecs[v].pt,
                 table_frame(vecs[v].body, vecs[v].blen),
                 1'b0, ~vecs[v].d, ~vecs[v].pe, ~vecs[v].pt, -1);
    end

    // Competing request during DATA is dropped and not queued.
    send_frame(8'hA5, 1'b0, 1'b0, table_frame(10'h14A, 9), 1'b0,
               8'h00, 1'b0, 1'b0, 4);
    check_idle(6);

    // Data_Valid held: one idle cycle between frames, then the next start bit.
    send_frame(8'hFF, 1'b0, 1'b0, ref_frame(8'hFF, 1'b0, 1'b0), 1'b1,
               8'h00, 1'b0, 1'b0, -1);
    send_frame(8'h00, 1'b0, 1'b0, ref_frame(8'h00, 1'b0, 1'b0), 1'b0,
               8'h3C, 1'b1, 1'b0, -1);
    check_idle(2);

    // Asynchronous reset during data bit 3 aborts the frame.
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("pre_reset_bit3", 0, TX_OUT, 1'b0);
    RST = 1'b1;
    #1;
    chk("abort_tx", 0, TX_OUT, 1'b1);
    chk("abort_busy", 0, Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    check_idle(12);

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      rd  = 8'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      q = ref_frame(rd, rpe, rpt);
      send_frame(rd, rpe, rpt, q, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), -1);
      check_idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Transmit-side frame controller for the UART TX path.
- Accepts a parallel byte with a valid strobe and sequences the serial frame: start, data bits LSB first, optional parity, stop.
- Holds its own data-bit counter and serializer and drives the TX line directly.
- Sits between the system-side byte source (register file or FIFO) and the TX pad.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5-8).

Ports:
- CLK  in  1  baud-rate clock; one bit period per cycle.
- RST  in  1  asynchronous reset, active-high.
- P_DATA  in  DATA_WIDTH  parallel byte to transmit.
- Data_Valid  in  1  P_DATA valid strobe; single-cycle or level.
- PAR_EN  in  1  1 = append parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- TX_OUT  out  1  serial line, idle-high; registered.
- Busy  out  1  frame in progress; registered.

Behaviour:
- Reset values: state=IDLE, TX_OUT=1, Busy=0, bit counter=0, shift/parity registers=0. Reset may assert at any time: line returns high asynchronously and the frame is aborted, with no partial completion.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - On a rising edge with Data_Valid=1: latch P_DATA, PAR_EN and PAR_TYP, compute parity, then go to START.
- START: TX_OUT=0, Busy=1, go to DATA.
- DATA:
  - TX_OUT = latched bit[counter], LSB first; counter increments each cycle.
  - When counter == DATA_WIDTH-1: clear counter; go to PARITY if latched PAR_EN=1, else STOP.
- PARITY:
  - TX_OUT = XOR of all latched data bits when PAR_TYP=0.
  - TX_OUT = inverse of that XOR when PAR_TYP=1.
  - Go to STOP.
- STOP: TX_OUT=1, Busy=1, go to IDLE.
- Timing (acceptance edge = k):
  - TX_OUT and Busy change on edge k.
  - Frame length is 1+DATA_WIDTH+PAR_EN+1 cycles: 10 cycles with parity off, 11 with parity on (DATA_WIDTH=8).
  - Busy falls on the edge that enters IDLE.
- Data_Valid while Busy=1 is ignored. There is no queueing.
- P_DATA, PAR_EN and PAR_TYP changes after acceptance have no effect on the current frame.
- Back-to-back: Data_Valid held high gives one IDLE cycle between frames. The line is high during that cycle.
- No other input affects state outside IDLE.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles, using an internal 1-bit stop counter. Frame length grows by 1 cycle: 11 (no parity) or 12 (parity).
- Undefined: single stop bit exactly as above, and no stop counter is synthesized.

Test Plan:
- Reset: RST=1 mid-frame (during DATA bit 3) -> TX_OUT=1 and Busy=0 immediately. After release the block stays IDLE until Data_Valid.
- Plain frame: P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. Busy high for exactly 10 cycles.
- Even parity: P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1. Busy high 11 cycles.
- Odd parity: P_DATA=0x03, PAR_EN=1, PAR_TYP=1 -> parity bit 1. Same frame with PAR_TYP=0 -> parity bit 0.
- Busy drop: second Data_Valid pulse with P_DATA=0x55 during the DATA state of a 0xA5 frame -> ignored; line shows only the 0xA5 frame, then stays idle-high.
- Back-to-back with UART_TX_TWO_STOP_EN defined: Data_Valid held high, P_DATA=0xFF then 0x00 -> two stop cycles, one IDLE cycle, then the next start bit. Each frame is 11 cycles with Busy high.
